// File: rtl/central_regs_pkg.sv
// Shared constants for the central register bank.
// Register indices, bus width and L partial-clear masks.
package central_regs_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] REG_A = 2'd0;
    localparam logic [1:0] REG_L = 2'd1;
    localparam logic [1:0] REG_Q = 2'd2;
    localparam logic [1:0] REG_Z = 2'd3;

    localparam logic [WIDTH-1:0] L_LO_MASK = 16'o037777;
    localparam logic [WIDTH-1:0] L_HI_MASK = 16'o140000;

    // shifted A write: bits 14:13 forced low, bits 12:1 loaded
    localparam logic [WIDTH-1:0] ALT_CLR_MASK = 16'o030000;
    localparam logic [WIDTH-1:0] ALT_WR_MASK  = 16'o007777;

endpackage

// File: rtl/central_register_bank_gated_reg.sv
// One central register with edge-detected write, two masked
// clears and an optional shifted write. Macro: AGC_MONITOR_EN.
module gated_reg
    import central_regs_pkg::*;
#(
    parameter int            W         = WIDTH,
    parameter logic [W-1:0]  RESET_VAL = '0,
    parameter logic [W-1:0]  CLR1_MASK = '1,
    parameter logic [W-1:0]  CLR2_MASK = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic         clr1,
    input  logic         clr2,
    input  logic         alt_wr,
    input  logic [W-1:0] wl,
    output logic [W-1:0] q
`ifdef AGC_MONITOR_EN
   ,output logic         wr_evt
`endif
);

    localparam logic [W-1:0] AC = ALT_CLR_MASK;
    localparam logic [W-1:0] AW = ALT_WR_MASK;

    logic [3:0]   gate;
    logic [3:0]   hist;
    logic [3:0]   ev;
    logic         alt_ok;
    logic [W-1:0] base;
    logic [W-1:0] nxt;

    assign gate   = {alt_wr, clr2, clr1, wr};
    assign ev     = gate & ~hist;
    assign alt_ok = ev[3] & ~wr;

`ifdef AGC_MONITOR_EN
    assign wr_evt = ev[0] | alt_ok;
`endif

    // remember last cycle's gate levels so a held gate acts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '0;
        else        hist <= gate;
    end

    // clear first, then OR the write data in
    always_comb begin
        base = q;
        if (ev[1]) base = base & ~CLR1_MASK;
        if (ev[2]) base = base & ~CLR2_MASK;
        nxt = base;
        if (ev[0])       nxt = base | wl;
        else if (alt_ok) nxt = (base & ~AC) | (wl & AW);
    end

    // register contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RESET_VAL;
        else        q <= nxt;
    end

endmodule

// File: rtl/central_register_bank.sv
// Central A/L/Q/Z register bank fed by the service-gate decoder.
// Optional write monitor outputs under macro AGC_MONITOR_EN.
module central_register_bank #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] Z_RESET = 16'o4000
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic [WIDTH-1:0] WL,
    input  logic             WAG_n,
    input  logic             WLG_n,
    input  logic             WQG_n,
    input  logic             WZG_n,
    input  logic             WALSG_n,
    input  logic             CAG,
    input  logic             CQG,
    input  logic             CZG,
    input  logic             CLG1G,
    input  logic             CLG2G,
    input  logic             RAG_n,
    input  logic             RLG_n,
    input  logic             RQG_n,
    input  logic             RZG_n,
    output logic [WIDTH-1:0] RL,
    output logic             A_OVF,
    output logic             A_SIGN
`ifdef AGC_MONITOR_EN
   ,output logic [WIDTH-1:0] MON_BUS,
    output logic [1:0]       MON_SEL
`endif
);

    import central_regs_pkg::*;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] l_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] z_q;

`ifdef AGC_MONITOR_EN
    logic [3:0] evt;
    logic [3:0] evt_d;
`endif

    gated_reg #(
        .W(WIDTH), .RESET_VAL('0),
        .CLR1_MASK('1), .CLR2_MASK('0)
    ) u_a (
        .clk(SIM_CLK), .rst_n(SIM_RST),
        .wr(~WAG_n), .clr1(CAG), .clr2(1'b0),
        .alt_wr(~WALSG_n), .wl(WL), .q(a_q)
`ifdef AGC_MONITOR_EN
       ,.wr_evt(evt[REG_A])
`endif
    );

    gated_reg #(
        .W(WIDTH), .RESET_VAL('0),
        .CLR1_MASK(L_LO_MASK), .CLR2_MASK(L_HI_MASK)
    ) u_l (
        .clk(SIM_CLK), .rst_n(SIM_RST),
        .wr(~WLG_n), .clr1(CLG1G), .clr2(CLG2G),
        .alt_wr(1'b0), .wl(WL), .q(l_q)
`ifdef AGC_MONITOR_EN
       ,.wr_evt(evt[REG_L])
`endif
    );

    gated_reg #(
        .W(WIDTH), .RESET_VAL('0),
        .CLR1_MASK('1), .CLR2_MASK('0)
    ) u_q (
        .clk(SIM_CLK), .rst_n(SIM_RST),
        .wr(~WQG_n), .clr1(CQG), .clr2(1'b0),
        .alt_wr(1'b0), .wl(WL), .q(q_q)
`ifdef AGC_MONITOR_EN
       ,.wr_evt(evt[REG_Q])
`endif
    );

    gated_reg #(
        .W(WIDTH), .RESET_VAL(Z_RESET),
        .CLR1_MASK('1), .CLR2_MASK('0)
    ) u_z (
        .clk(SIM_CLK), .rst_n(SIM_RST),
        .wr(~WZG_n), .clr1(CZG), .clr2(1'b0),
        .alt_wr(1'b0), .wl(WL), .q(z_q)
`ifdef AGC_MONITOR_EN
       ,.wr_evt(evt[REG_Z])
`endif
    );

    // wired-OR read bus, forced quiet while reset is held
    always_comb begin
        RL = '0;
        if (SIM_RST) begin
            if (!RAG_n) RL = RL | a_q;
            if (!RLG_n) RL = RL | l_q;
            if (!RQG_n) RL = RL | q_q;
            if (!RZG_n) RL = RL | z_q;
        end
    end

    // sign and overflow flags trail A by one cycle
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            A_OVF  <= 1'b0;
            A_SIGN <= 1'b0;
        end else begin
            A_OVF  <= a_q[WIDTH-1] ^ a_q[WIDTH-2];
            A_SIGN <= a_q[WIDTH-1];
        end
    end

`ifdef AGC_MONITOR_EN
    // hold write events so the monitor sees the settled value
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) evt_d <= '0;
        else          evt_d <= evt;
    end

    // capture the highest-priority freshly written register
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            MON_BUS <= '0;
            MON_SEL <= '0;
        end else if (evt_d[REG_A]) begin
            MON_BUS <= a_q;
            MON_SEL <= REG_A;
        end else if (evt_d[REG_L]) begin
            MON_BUS <= l_q;
            MON_SEL <= REG_L;
        end else if (evt_d[REG_Q]) begin
            MON_BUS <= q_q;
            MON_SEL <= REG_Q;
        end else if (evt_d[REG_Z]) begin
            MON_BUS <= z_q;
            MON_SEL <= REG_Z;
        end
    end
`endif

endmodule

// File: tb/tb_central_register_bank.sv
// Bench for central_register_bank: directed plan then random
// gates, checked every cycle against a behavioural model.
module tb_central_register_bank;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic [15:0] WL;
    logic        WAG_n, WLG_n, WQG_n, WZG_n, WALSG_n;
    logic        CAG, CQG, CZG, CLG1G, CLG2G;
    logic        RAG_n, RLG_n, RQG_n, RZG_n;
    logic [15:0] RL;
    logic        A_OVF, A_SIGN;
`ifdef AGC_MONITOR_EN
    logic [15:0] MON_BUS;
    logic [1:0]  MON_SEL;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    central_register_bank dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .WL(WL),
        .WAG_n(WAG_n), .WLG_n(WLG_n), .WQG_n(WQG_n),
        .WZG_n(WZG_n), .WALSG_n(WALSG_n),
        .CAG(CAG), .CQG(CQG), .CZG(CZG),
        .CLG1G(CLG1G), .CLG2G(CLG2G),
        .RAG_n(RAG_n), .RLG_n(RLG_n), .RQG_n(RQG_n),
        .RZG_n(RZG_n), .RL(RL), .A_OVF(A_OVF), .A_SIGN(A_SIGN)
`ifdef AGC_MONITOR_EN
       ,.MON_BUS(MON_BUS), .MON_SEL(MON_SEL)
`endif
    );

    always #5 SIM_CLK = ~SIM_CLK;

    // ---------------- behavioural model ----------------
    logic [15:0] m_a = 16'h0;
    logic [15:0] m_l = 16'h0;
    logic [15:0] m_q = 16'h0;
    logic [15:0] m_z = 16'o4000;
    logic        m_ovf = 1'b0;
    logic        m_sign = 1'b0;
    logic [9:0]  prev = 10'h0;
`ifdef AGC_MONITOR_EN
    logic [15:0] m_mbus = 16'h0;
    logic [1:0]  m_msel = 2'd0;
    int          m_pend = -1;
`endif

    // 0 wa 1 wl 2 wq 3 wz 4 walsg 5 ca 6 cq 7 cz 8 clg1 9 clg2
    function automatic logic [9:0] now_g();
        return {CLG2G, CLG1G, CZG, CQG, CAG,
                !WALSG_n, !WZG_n, !WQG_n, !WLG_n, !WAG_n};
    endfunction

    function automatic logic e(int i);
        logic [9:0] g;
        g = now_g();
        return g[i] && !prev[i];
    endfunction

    function automatic logic [15:0] next_a();
        logic [15:0] v;
        v = e(5) ? 16'h0 : m_a;
        if (e(0)) v = v | WL;
        else if (e(4) && WAG_n)
            v = (v & 16'o140000) | ((v | WL) & 16'o007777);
        return v;
    endfunction

    function automatic logic [15:0] next_l();
        logic [15:0] v;
        v = m_l;
        if (e(8)) v = v & 16'o140000;
        if (e(9)) v = v & 16'o037777;
        if (e(1)) v = v | WL;
        return v;
    endfunction

    function automatic logic [15:0] simple(logic [15:0] cur,
                                           logic clr, logic wr);
        return (clr ? 16'h0 : cur) | (wr ? WL : 16'h0);
    endfunction

`ifdef AGC_MONITOR_EN
    function automatic int first_write();
        if (e(0) || (e(4) && WAG_n)) return 0;
        if (e(1)) return 1;
        if (e(2)) return 2;
        if (e(3)) return 3;
        return -1;
    endfunction

    function automatic logic [15:0] regval(int i);
        case (i)
            0: return m_a;
            1: return m_l;
            2: return m_q;
            default: return m_z;
        endcase
    endfunction
`endif

    function automatic logic [15:0] model_rl();
        logic [15:0] v;
        v = 16'h0;
        if (!SIM_RST) return v;
        if (!RAG_n) v = v | m_a;
        if (!RLG_n) v = v | m_l;
        if (!RQG_n) v = v | m_q;
        if (!RZG_n) v = v | m_z;
        return v;
    endfunction

    always @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            m_a <= 16'h0; m_l <= 16'h0; m_q <= 16'h0;
            m_z <= 16'o4000; m_ovf <= 1'b0; m_sign <= 1'b0;
            prev <= 10'h0;
`ifdef AGC_MONITOR_EN
            m_mbus <= 16'h0; m_msel <= 2'd0; m_pend <= -1;
`endif
        end else begin
            m_a <= next_a();
            m_l <= next_l();
            m_q <= simple(m_q, e(6), e(2));
            m_z <= simple(m_z, e(7), e(3));
            m_ovf <= m_a[15] ^ m_a[14];
            m_sign <= m_a[15];
`ifdef AGC_MONITOR_EN
            if (m_pend >= 0) begin
                m_msel <= 2'(m_pend);
                m_mbus <= regval(m_pend);
            end
            m_pend <= first_write();
`endif
            prev <= now_g();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %o expected %o @%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge SIM_CLK) begin
        if (chk_en) begin
            #2;
            chk("rl", RL, model_rl());
            chk("a_ovf", {15'h0, A_OVF}, {15'h0, m_ovf});
            chk("a_sign", {15'h0, A_SIGN}, {15'h0, m_sign});
`ifdef AGC_MONITOR_EN
            chk("mon_bus", MON_BUS, m_mbus);
            chk("mon_sel", {14'h0, MON_SEL}, {14'h0, m_msel});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic nx();
        @(negedge SIM_CLK);
    endtask

    task automatic idle();
        WL = 16'h0;
        WAG_n = 1'b1; WLG_n = 1'b1; WQG_n = 1'b1; WZG_n = 1'b1;
        WALSG_n = 1'b1;
        CAG = 1'b0; CQG = 1'b0; CZG = 1'b0;
        CLG1G = 1'b0; CLG2G = 1'b0;
        RAG_n = 1'b1; RLG_n = 1'b1; RQG_n = 1'b1; RZG_n = 1'b1;
    endtask

    task automatic lit(input string nm, input logic [15:0] exp);
        #3;
        chk(nm, RL, exp);
        chk({nm, "_model"}, model_rl(), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        SIM_RST = 1'b0;
        RAG_n = 1'b0; RLG_n = 1'b0; RQG_n = 1'b0; RZG_n = 1'b0;
        repeat (3) nx();
        chk_en = 1'b1;
        nx();
        lit("rst_rl", 16'h0);

        nx(); SIM_RST = 1'b1;
        lit("rel_rl", 16'o4000);
        chk("rel_ovf", {15'h0, A_OVF}, 16'h0);

        nx(); RAG_n = 1'b1; RLG_n = 1'b1; RQG_n = 1'b1; RZG_n = 1'b1;
        WL = 16'o12345; CAG = 1'b1; WAG_n = 1'b0;
        nx(); CAG = 1'b0; WAG_n = 1'b1; RAG_n = 1'b0;
        lit("a_clr_wr", 16'o12345);
        nx(); WL = 16'o2; WAG_n = 1'b0;
        nx(); WAG_n = 1'b1;
        lit("a_or", 16'o12347);

        RAG_n = 1'b1; RQG_n = 1'b0;
        nx(); WQG_n = 1'b0; WL = 16'o1;
        nx(); WL = 16'o2;
        nx(); WL = 16'o4;
        nx();
        nx();
        nx(); WQG_n = 1'b1;
        lit("q_held", 16'o1);
        nx(); WQG_n = 1'b0;
        nx(); WQG_n = 1'b1;
        lit("q_rearm", 16'o5);

        RQG_n = 1'b1; RLG_n = 1'b0;
        nx(); WL = 16'o177777; WLG_n = 1'b0;
        nx(); WLG_n = 1'b1;
        lit("l_load", 16'o177777);
        nx(); CLG1G = 1'b1;
        nx(); CLG1G = 1'b0;
        lit("l_clg1", 16'o140000);
        nx(); CLG2G = 1'b1;
        nx(); CLG2G = 1'b0;
        lit("l_clg2", 16'h0);

        RLG_n = 1'b1; RAG_n = 1'b0;
        nx(); CAG = 1'b1;
        nx(); CAG = 1'b0; WL = 16'o037777; WALSG_n = 1'b0;
        nx(); WALSG_n = 1'b1;
        lit("a_walsg", 16'o007777);
        nx(); WL = 16'o040000; WAG_n = 1'b0;
        nx(); WAG_n = 1'b1;
        lit("a_sgn2", 16'o047777);
        chk("ovf_lag", {15'h0, A_OVF}, 16'h0);
        nx();
        #3 chk("ovf_set", {15'h0, A_OVF}, 16'h1);
        chk("sign_clr", {15'h0, A_SIGN}, 16'h0);

`ifdef AGC_MONITOR_EN
        nx(); WL = 16'o7; CQG = 1'b1; CZG = 1'b1;
        WQG_n = 1'b0; WZG_n = 1'b0;
        nx(); CQG = 1'b0; CZG = 1'b0; WQG_n = 1'b1; WZG_n = 1'b1;
        nx();
        #3 chk("mon_sel_lit", {14'h0, MON_SEL}, 16'd2);
        chk("mon_bus_lit", MON_BUS, 16'o7);
`endif

        nx(); WL = 16'o5; WAG_n = 1'b0; RZG_n = 1'b0;
        SIM_RST = 1'b0;
        lit("midrst_rl", 16'h0);
        chk("midrst_ovf", {15'h0, A_OVF}, 16'h0);
`ifdef AGC_MONITOR_EN
        chk("midrst_mon", MON_BUS, 16'h0);
`endif
        nx(); SIM_RST = 1'b1;
        nx(); WAG_n = 1'b1;
        lit("fresh_evt", 16'o4005);

        for (int i = 0; i < 800; i++) begin
            nx();
            SIM_RST = ($urandom_range(0, 63) != 0);
            WL = 16'($urandom);
            WAG_n   = ($urandom_range(0, 3) != 0);
            WLG_n   = ($urandom_range(0, 3) != 0);
            WQG_n   = ($urandom_range(0, 3) != 0);
            WZG_n   = ($urandom_range(0, 3) != 0);
            WALSG_n = ($urandom_range(0, 3) != 0);
            CAG   = ($urandom_range(0, 7) == 0);
            CQG   = ($urandom_range(0, 7) == 0);
            CZG   = ($urandom_range(0, 7) == 0);
            CLG1G = ($urandom_range(0, 7) == 0);
            CLG2G = ($urandom_range(0, 7) == 0);
            RAG_n = 1'($urandom);
            RLG_n = 1'($urandom);
            RQG_n = 1'($urandom);
            RZG_n = 1'($urandom);
        end
        nx(); SIM_RST = 1'b1; idle();
        nx();
        nx();
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
